// File: rtl/paridade_stream.sv
// paridade_stream: framed parity generator/checker on a valid/ready stream.
// Accumulates the XOR of every accepted WIDTH-bit word until in_last, then
// presents one registered result per frame (parity, check error, length) and
// holds it until the consumer takes it. A saturating counter tracks how many
// erroneous frames have been delivered.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   word handshake (in_ready registered, high in ACC)
//   in_data, in_last    data word and end-of-frame marker
//   mode_odd, check_en, exp_par   frame controls, sampled with the last word
//   out_valid/out_ready result handshake (out_valid registered, high in HOLD)
//   out_par, out_err, out_len     frame result, stable while out_valid
//   err_cnt             saturating count of delivered frames with out_err
module paridade_stream #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             mode_odd,
  input  logic             check_en,
  input  logic             exp_par,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_par,
  output logic             out_err,
  output logic [CNT_W-1:0] out_len,
  output logic [CNT_W-1:0] err_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t           state;
  logic             acc;
  logic [CNT_W-1:0] wc;

  logic             word_par;
  logic             frame_par;
  logic [CNT_W-1:0] wc_inc;
  logic [CNT_W-1:0] err_inc;

  // Parity of the incoming word and of the whole frame if this word is last.
  assign word_par  = ^in_data;
  assign frame_par = acc ^ word_par ^ mode_odd;

  // Saturating increments: counters stick at all-ones instead of wrapping.
  assign wc_inc  = (wc == CNT_MAX) ? wc : wc + CNT_ONE;
  assign err_inc = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CNT_ONE;

  // Frame FSM; in_ready/out_valid are kept as flops that mirror the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACC;
      acc       <= 1'b0;
      wc        <= '0;
      err_cnt   <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_par   <= 1'b0;
      out_err   <= 1'b0;
      out_len   <= '0;
    end else begin
      case (state)
        ACC: begin
          if (in_valid) begin
            if (in_last) begin
              out_par   <= frame_par;
              out_err   <= check_en & (exp_par != frame_par);
              out_len   <= wc_inc;
              acc       <= 1'b0;
              wc        <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              acc <= acc ^ word_par;
              wc  <= wc_inc;
            end
          end
        end
        HOLD: begin
          // Result stays frozen until the consumer takes it.
          if (out_ready) begin
            if (out_err) err_cnt <= err_inc;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            state     <= ACC;
          end
        end
        default: begin
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          state     <= ACC;
        end
      endcase
    end
  end

endmodule
